// File: rtl/addsub_result_fifo.sv
// Result FIFO for an add/sub unit: stores each result with {N,Z,V,OP} flags and keeps a sticky overflow bit.
// Define ADDSUB_SAT_EN to saturate overflowed results before they are stored.
module addsub_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_sum,
  input  logic                     in_of,
  input  logic                     in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_of,
  input  logic                     clr_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic            sticky_q, sticky_d;
  logic [19:0]     mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [15:0]     storeSum;
  logic [3:0]      storeFlags;
  logic [19:0]     head;

  assign in_ready  = (state_q != StFull) & ~rst;
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flags describe the value actually stored, so saturation (if built in) comes first.
  always_comb begin
`ifdef ADDSUB_SAT_EN
    if (in_of) begin
      storeSum = in_sum[15] ? 16'h7FFF : 16'h8000;
    end else begin
      storeSum = in_sum;
    end
`else
    storeSum = in_sum;
`endif
    storeFlags = {storeSum[15], (storeSum == 16'h0000), in_of, in_op};
  end

  always_comb begin
    count_d  = count_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    sticky_d = sticky_q;
    state_d  = state_q;

    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Clear first so that a simultaneous overflow push keeps the bit set.
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (push && in_of) begin
      sticky_d = 1'b1;
    end

    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == DepthC) begin
      state_d = StFull;
    end else begin
      state_d = StPartial;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the output is masked.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {storeFlags, storeSum};
    end
  end

  assign head      = mem_q[rdPtr_q];
  assign out_data  = out_valid ? head[15:0] : 16'h0000;
  assign out_flags = out_valid ? head[19:16] : 4'h0;
  assign count     = count_q;
  assign sticky_of = sticky_q;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Randomized bench for addsub_result_fifo: a queue-based reference model updates on each rising edge,
// a monitor compares every DUT output against it on the falling edge.
module tb_addsub_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_sum;
  logic            in_of;
  logic            in_op;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic [3:0]      out_flags;
  logic [CW-1:0]   count;
  logic            sticky_of;
  logic            clr_sticky;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] model[$];
  logic        modelSticky = 1'b0;

  addsub_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_of(in_of), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .count(count), .sticky_of(sticky_of), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] s, input logic of,
                               input logic op, input logic ordy, input logic clr);
    rst = r; in_valid = v; in_sum = s; in_of = of; in_op = op; out_ready = ordy; clr_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] makeEntry(input logic [15:0] s, input logic of, input logic op);
    logic [15:0] stored;
    stored = s;
`ifdef ADDSUB_SAT_EN
    if (of) stored = s[15] ? 16'h7FFF : 16'h8000;
`endif
    return {stored[15], stored == 16'h0000, of, op, stored};
  endfunction

  // Reference model: occupancy and order follow directly from queue size and push_back/pop_front.
  initial begin
    forever begin
      bit canPush, canPop;
      @(posedge clk);
      if (rst) begin
        model.delete();
        modelSticky = 1'b0;
      end else begin
        canPush = in_valid && (model.size() < DEPTH);
        canPop  = out_ready && (model.size() > 0);
        if (canPop) void'(model.pop_front());
        if (canPush) model.push_back(makeEntry(in_sum, in_of, in_op));
        if (clr_sticky) modelSticky = 1'b0;
        if (canPush && in_of) modelSticky = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      logic [19:0] exp;
      @(negedge clk);
      exp = (model.size() > 0) ? model[0] : 20'h0;
      checkOutput("count", int'(count), model.size());
      checkOutput("out_valid", int'(out_valid), int'(model.size() > 0));
      checkOutput("in_ready", int'(in_ready), int'((model.size() < DEPTH) && !rst));
      checkOutput("out_data", int'(out_data), int'(exp[15:0]));
      checkOutput("out_flags", int'(out_flags), int'(exp[19:16]));
      checkOutput("sticky_of", int'(sticky_of), int'(modelSticky));
    end
  end

  initial begin
    logic [15:0] fillVals [4];
    fillVals[0] = 16'h0000; fillVals[1] = 16'h8001; fillVals[2] = 16'h1234; fillVals[3] = 16'h7FFF;
    $display("[TB] starting");

    applyStimulus(1, 0, 16'h0, 0, 0, 0, 0);
    applyStimulus(1, 0, 16'h0, 0, 0, 0, 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);

    applyStimulus(0, 1, 16'h0005, 0, 1, 0, 0);
    checkOutput("single_data", int'(out_data), 'h0005);
    checkOutput("single_flags", int'(out_flags), 'b0001);
    checkOutput("single_count", int'(count), 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, fillVals[i], 0, i[0], 0, 0);
    applyStimulus(0, 1, 16'h5555, 0, 1, 0, 0);
    checkOutput("full_count", int'(count), DEPTH);
    checkOutput("full_in_ready", int'(in_ready), 0);
    checkOutput("full_head", int'(out_data), 'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0, 0, 0, 1, 0);

    applyStimulus(0, 1, 16'h1111, 0, 1, 0, 0);
    applyStimulus(0, 1, 16'h2222, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 16'h3000 + 16'(i), 0, i[0], 1, 0);
    checkOutput("stream_count", int'(count), 2);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 16'h0, 0, 0, 1, 0);

    applyStimulus(0, 1, 16'h8000, 1, 1, 0, 0);
`ifdef ADDSUB_SAT_EN
    checkOutput("sat_data", int'(out_data), 'h7FFF);
    checkOutput("sat_flags", int'(out_flags), 'b0011);
`else
    checkOutput("nosat_data", int'(out_data), 'h8000);
    checkOutput("nosat_flags", int'(out_flags), 'b1011);
`endif
    checkOutput("sticky_set", int'(sticky_of), 1);
    applyStimulus(0, 1, 16'h7000, 1, 0, 0, 1);
    checkOutput("sticky_set_wins", int'(sticky_of), 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 0, 1);
    checkOutput("sticky_cleared", int'(sticky_of), 0);

    applyStimulus(0, 1, 16'h4444, 1, 1, 0, 0);
    checkOutput("pre_reset_count", int'(count), 3);
    applyStimulus(1, 1, 16'h9999, 0, 1, 1, 0);
    checkOutput("mid_reset_count", int'(count), 0);
    checkOutput("mid_reset_data", int'(out_data), 0);
    checkOutput("mid_reset_sticky", int'(sticky_of), 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 0, 0);
    checkOutput("post_reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] s;
      case ($urandom_range(0, 7))
        0: s = 16'h0000;
        1: s = 16'h8000;
        2: s = 16'h7FFF;
        default: s = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, s,
                    $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
